// File: rtl/avalonst_downsizer.sv
// Splits each wide Avalon-ST word into RATIO narrow beats, LSB slice first.
// Latency: beat 0 is presented the cycle after the wide word is accepted.
// Backpressure: the sink stalls until the last beat leaves; that beat and the next word may transfer together.
module avalonst_downsizer #(
    parameter int IN_WIDTH  = 512,
    parameter int OUT_WIDTH = 64
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_snk_vld,
    input  logic [IN_WIDTH-1:0]  i_snk_data,
    output logic                 o_snk_rdy,
    output logic                 o_src_vld,
    output logic [OUT_WIDTH-1:0] o_src_data,
    input  logic                 i_src_rdy,
    output logic                 o_busy
);

    localparam int RATIO = IN_WIDTH / OUT_WIDTH;
    localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(RATIO - 1);

    generate
        if ((IN_WIDTH % OUT_WIDTH) != 0 || RATIO < 2) begin : g_bad_ratio
            $error("avalonst_downsizer: IN_WIDTH must be an integer multiple (>=2) of OUT_WIDTH");
        end
    endgenerate

    typedef enum logic {
        EMPTY     = 1'b0,
        SERIALIZE = 1'b1
    } state_t;

    state_t                            state;
    logic [CNT_W-1:0]                  cnt;
    logic [RATIO-1:0][OUT_WIDTH-1:0]   hold;
    logic                              last_beat;
    logic                              snk_xfer;
    logic                              src_xfer;

    assign last_beat  = (cnt == LAST_BEAT);
    assign o_src_vld  = (state == SERIALIZE);
    assign o_busy     = (state == SERIALIZE);
    assign o_src_data = hold[cnt];
    // Only path from i_src_rdy to o_snk_rdy: lets the last beat and the next word overlap.
    assign o_snk_rdy  = (state == EMPTY) || (last_beat && i_src_rdy);
    assign snk_xfer   = i_snk_vld && o_snk_rdy;
    assign src_xfer   = o_src_vld && i_src_rdy;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= EMPTY;
            cnt   <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (snk_xfer) begin
                        state <= SERIALIZE;
                        cnt   <= '0;
                    end
                end
                SERIALIZE: begin
                    if (src_xfer) begin
                        if (last_beat) begin
                            cnt   <= '0;
                            state <= snk_xfer ? SERIALIZE : EMPTY;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state <= EMPTY;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Payload needs no reset: it is only observed while o_src_vld is high.
    always_ff @(posedge i_clk) begin
        if (snk_xfer) begin
            hold <= i_snk_data;
        end
    end

endmodule

// File: tb/tb_avalonst_downsizer.sv
// Self-checking bench for avalonst_downsizer at 32->8 bits: vector table, reset corner case, random scoreboard.
module tb_avalonst_downsizer;

    localparam int IW = 32;
    localparam int OW = 8;
    localparam int NWORDS = 10000;

    logic          clk;
    logic          rst_n;
    logic          snk_vld;
    logic [IW-1:0] snk_data;
    logic          snk_rdy;
    logic          src_vld;
    logic [OW-1:0] src_data;
    logic          src_rdy;
    logic          busy;

    int checks = 0;
    int errors = 0;

    avalonst_downsizer #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_snk_vld  (snk_vld),
        .i_snk_data (snk_data),
        .o_snk_rdy  (snk_rdy),
        .o_src_vld  (src_vld),
        .o_src_data (src_data),
        .i_src_rdy  (src_rdy),
        .o_busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          snk_vld;
        logic [IW-1:0] snk_data;
        logic          src_rdy;
        logic          exp_vld;
        logic [OW-1:0] exp_data;
        logic          exp_snk_rdy;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic sv, input logic [IW-1:0] sd, input logic sr,
                       input logic ev, input logic [OW-1:0] ed, input logic er);
        vec_t v;
        v.snk_vld = sv; v.snk_data = sd; v.src_rdy = sr;
        v.exp_vld = ev; v.exp_data = ed; v.exp_snk_rdy = er;
        tbl.push_back(v);
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_beat(input string name, input logic [OW-1:0] exp);
        chk({name, "_vld"}, 32'(src_vld), 32'd1);
        chk({name, "_data"}, 32'(src_data), 32'(exp));
    endtask

    logic [OW-1:0] model_q[$];

    initial begin
        rst_n    = 1'b0;
        snk_vld  = 1'b0;
        snk_data = '0;
        src_rdy  = 1'b0;
        #1;
        chk("reset_vld", 32'(src_vld), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_snk_rdy", 32'(snk_rdy), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();

        // single word
        add(1, 32'hDDCCBBAA, 1, 0, 8'h00, 1);
        add(0, 32'h0,        1, 1, 8'hAA, 0);
        add(0, 32'h0,        1, 1, 8'hBB, 0);
        add(0, 32'h0,        1, 1, 8'hCC, 0);
        add(0, 32'h0,        1, 1, 8'hDD, 1);
        // back-to-back
        add(1, 32'h04030201, 1, 0, 8'h00, 1);
        add(1, 32'h08070605, 1, 1, 8'h01, 0);
        add(1, 32'h08070605, 1, 1, 8'h02, 0);
        add(1, 32'h08070605, 1, 1, 8'h03, 0);
        add(1, 32'h08070605, 1, 1, 8'h04, 1);
        add(0, 32'h0,        1, 1, 8'h05, 0);
        add(0, 32'h0,        1, 1, 8'h06, 0);
        add(0, 32'h0,        1, 1, 8'h07, 0);
        add(0, 32'h0,        1, 1, 8'h08, 1);
        // backpressure; sink data toggling while stalled must be ignored
        add(1, 32'hA4A3A2A1, 1, 0, 8'h00, 1);
        add(1, 32'h5555AAAA, 0, 1, 8'hA1, 0);
        add(1, 32'h12345678, 0, 1, 8'hA1, 0);
        add(0, 32'h0,        1, 1, 8'hA1, 0);
        add(0, 32'h0,        0, 1, 8'hA2, 0);
        add(0, 32'h0,        0, 1, 8'hA2, 0);
        add(0, 32'h0,        1, 1, 8'hA2, 0);
        add(0, 32'h0,        1, 1, 8'hA3, 0);
        add(1, 32'hFFFFFFFF, 0, 1, 8'hA4, 0);
        add(0, 32'h0,        1, 1, 8'hA4, 1);
        // sink stall between words
        add(1, 32'h14131211, 1, 0, 8'h00, 1);
        add(0, 32'h0,        1, 1, 8'h11, 0);
        add(0, 32'h0,        1, 1, 8'h12, 0);
        add(0, 32'h0,        1, 1, 8'h13, 0);
        add(0, 32'h0,        1, 1, 8'h14, 1);
        add(0, 32'h0,        1, 0, 8'h00, 1);
        add(0, 32'h0,        1, 0, 8'h00, 1);
        add(0, 32'h0,        1, 0, 8'h00, 1);
        add(1, 32'h24232221, 1, 0, 8'h00, 1);
        add(0, 32'h0,        1, 1, 8'h21, 0);
        add(0, 32'h0,        1, 1, 8'h22, 0);
        add(0, 32'h0,        1, 1, 8'h23, 0);
        add(0, 32'h0,        1, 1, 8'h24, 1);
        add(0, 32'h0,        1, 0, 8'h00, 1);

        foreach (tbl[i]) begin
            snk_vld  = tbl[i].snk_vld;
            snk_data = tbl[i].snk_data;
            src_rdy  = tbl[i].src_rdy;
            #1;
            chk($sformatf("vec%0d_vld", i), 32'(src_vld), 32'(tbl[i].exp_vld));
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].exp_vld));
            chk($sformatf("vec%0d_snk_rdy", i), 32'(snk_rdy), 32'(tbl[i].exp_snk_rdy));
            if (tbl[i].exp_vld)
                chk($sformatf("vec%0d_data", i), 32'(src_data), 32'(tbl[i].exp_data));
            step();
        end

        // reset mid-word: takes effect without a clock edge
        snk_vld = 1'b1; snk_data = 32'hDDCCBBAA; src_rdy = 1'b1;
        step();
        snk_vld = 1'b0; snk_data = '0;
        #1; check_beat("rst_b0", 8'hAA);
        step();
        #1; check_beat("rst_b1", 8'hBB);
        step();
        rst_n = 1'b0;
        #1;
        chk("rst_mid_vld", 32'(src_vld), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_snk_rdy", 32'(snk_rdy), 32'd1);
        step();
        rst_n = 1'b1;
        step();
        chk("rst_after_vld", 32'(src_vld), 32'd0);
        snk_vld = 1'b1; snk_data = 32'h44332211;
        step();
        snk_vld = 1'b0; snk_data = '0;
        #1; check_beat("post_rst_b0", 8'h11);
        step(); #1; check_beat("post_rst_b1", 8'h22);
        step(); #1; check_beat("post_rst_b2", 8'h33);
        step(); #1; check_beat("post_rst_b3", 8'h44);
        step(); #1;
        chk("post_rst_idle", 32'(src_vld), 32'd0);
        step();

        // randomized traffic against a beat queue
        begin
            int            words = 0;
            int            cyc   = 0;
            logic          prev_stall = 1'b0;
            logic [OW-1:0] prev_data  = '0;
            logic [IW-1:0] w;
            while (words < NWORDS && cyc < 90000) begin
                snk_vld  = ($urandom_range(15) != 0);
                snk_data = $urandom;
                src_rdy  = ($urandom_range(7) != 0);
                #1;
                chk("rnd_vld", 32'(src_vld), 32'(model_q.size() != 0));
                chk("rnd_busy", 32'(busy), 32'(model_q.size() != 0));
                chk("rnd_snk_rdy", 32'(snk_rdy),
                    32'(model_q.size() == 0 || (model_q.size() == 1 && src_rdy)));
                if (prev_stall) begin
                    chk("rnd_hold_vld", 32'(src_vld), 32'd1);
                    chk("rnd_hold_data", 32'(src_data), 32'(prev_data));
                end
                if (src_vld && src_rdy) begin
                    if (model_q.size() == 0) begin
                        chk("rnd_unexpected_beat", 32'(src_data), 32'hFFFF_FFFF);
                    end else begin
                        chk("rnd_beat", 32'(src_data), 32'(model_q.pop_front()));
                    end
                end
                if (snk_vld && snk_rdy) begin
                    w = snk_data;
                    for (int k = 0; k < IW / OW; k++)
                        model_q.push_back(OW'(w >> (k * OW)));
                    words++;
                end
                prev_stall = src_vld && !src_rdy;
                prev_data  = src_data;
                step();
                cyc++;
            end
            chk("rnd_words_accepted", 32'(words), 32'(NWORDS));
            snk_vld = 1'b0;
            src_rdy = 1'b1;
            cyc = 0;
            while (model_q.size() != 0 && cyc < 20) begin
                #1;
                if (src_vld)
                    chk("drain_beat", 32'(src_data), 32'(model_q.pop_front()));
                step();
                cyc++;
            end
            chk("drain_empty", 32'(model_q.size()), 32'd0);
            #1;
            chk("drain_idle", 32'(src_vld), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
